// File: rtl/cp0_pkg.sv
// CP0 register addresses, field positions, exception codes and sequencer state encoding
// shared by the CP0 register file and the exception sequencer.
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int ST_IE      = 0;
  localparam int ST_EXL     = 1;
  localparam int ST_IM_LO   = 8;
  localparam int CA_IPSW_LO = 8;

  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_BP  = 5'd9,
    EXC_RI  = 5'd10,
    EXC_OV  = 5'd12
  } exc_code_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_FLUSH     = 2'd1;
  localparam state_t ST_REDIRECT  = 2'd2;
  localparam state_t ST_ERET_WAIT = 2'd3;

  function automatic logic mtc0_hit(input logic we, input logic [4:0] addr,
                                    input logic [2:0] sel, input logic [4:0] target);
    return we && (sel == 3'd0) && (addr == target);
  endfunction

endpackage

// File: rtl/cp0_regs.sv
// Status/Cause/EPC storage. Software mtc0 writes land first, then hardware
// exception entry and eret overwrite only the fields they own.
module cp0_regs
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  int_req,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_wdata,
  input  logic        entry,
  input  logic [4:0]  entry_code,
  input  logic [31:0] entry_pc,
  input  logic        eret_clr,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic [31:0] epc_next,
  output logic        epc_wr,
  output logic        int_pending
);

  logic        ie_q, ie_d, exl_q, exl_d;
  logic [7:0]  im_q, im_d;
  logic [1:0]  ipsw_q, ipsw_d;
  logic [5:0]  iphw_q;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic        wr_status, wr_cause;

  assign wr_status = mtc0_hit(mtc0_we, mtc0_addr, mtc0_sel, CP0_STATUS);
  assign wr_cause  = mtc0_hit(mtc0_we, mtc0_addr, mtc0_sel, CP0_CAUSE);
  assign epc_wr    = mtc0_hit(mtc0_we, mtc0_addr, mtc0_sel, CP0_EPC);
  // An eret in the same cycle as an mtc0 to EPC must return to the new value.
  assign epc_next  = epc_wr ? mtc0_wdata : epc_q;

  always_comb begin
    ie_d   = ie_q;
    exl_d  = exl_q;
    im_d   = im_q;
    ipsw_d = ipsw_q;
    code_d = code_q;
    epc_d  = epc_next;
    if (wr_status) begin
      ie_d  = mtc0_wdata[ST_IE];
      exl_d = mtc0_wdata[ST_EXL];
      im_d  = mtc0_wdata[ST_IM_LO +: 8];
    end
    if (wr_cause) ipsw_d = mtc0_wdata[CA_IPSW_LO +: 2];
    if (entry) begin
      epc_d  = entry_pc;
      code_d = entry_code;
      exl_d  = 1'b1;
    end
    if (eret_clr) exl_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      im_q   <= '0;
      ipsw_q <= '0;
      iphw_q <= '0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      ie_q   <= ie_d;
      exl_q  <= exl_d;
      im_q   <= im_d;
      ipsw_q <= ipsw_d;
      iphw_q <= int_req;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

  assign status      = {16'h0, im_q, 6'h0, exl_q, ie_q};
  assign cause       = {16'h0, iphw_q, ipsw_q, 1'b0, code_q, 2'b00};
  assign epc         = epc_q;
  assign int_pending = ie_q && !exl_q && (({iphw_q, ipsw_q} & im_q) != 8'h0);

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt entry and eret sequencer: flushes the pipeline, then
// redirects fetch to the exception vector or back to EPC.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0800,
  parameter int          FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  int_req,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] mem_pc,
  input  logic        eret_req,
  input  logic [1:0]  cp0bubble,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_wdata,
  output logic        flush,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc
);

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d, redir_q, redir_d;
  logic [31:0] target_q, target_d;
  logic        entry, eret_clr, int_pending, epc_wr;
  logic [4:0]  entry_code;
  logic [31:0] epc_next;

  cp0_regs u_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .int_req     (int_req),
    .mtc0_we     (mtc0_we),
    .mtc0_addr   (mtc0_addr),
    .mtc0_sel    (mtc0_sel),
    .mtc0_wdata  (mtc0_wdata),
    .entry       (entry),
    .entry_code  (entry_code),
    .entry_pc    (mem_pc),
    .eret_clr    (eret_clr),
    .status      (status),
    .cause       (cause),
    .epc         (epc),
    .epc_next    (epc_next),
    .epc_wr      (epc_wr),
    .int_pending (int_pending)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flush_d    = 1'b0;
    redir_d    = 1'b0;
    target_d   = target_q;
    entry      = 1'b0;
    entry_code = exc_code;
    eret_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exc_valid || int_pending) begin
          entry   = 1'b1;
          if (!exc_valid) entry_code = EXC_INT;
          cnt_d   = CNT_INIT;
          flush_d = 1'b1;
          state_d = ST_FLUSH;
        end else if (eret_req) begin
          if (cp0bubble == 2'd0) begin
            eret_clr = 1'b1;
            flush_d  = 1'b1;
            redir_d  = 1'b1;
            target_d = epc_next;
          end else begin
            state_d = ST_ERET_WAIT;
          end
        end
      end
      ST_FLUSH: begin
        flush_d = 1'b1;
        if (cnt_q == 3'd0) begin
          redir_d  = 1'b1;
          target_d = EXC_VECTOR;
          state_d  = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_REDIRECT: state_d = ST_IDLE;
      ST_ERET_WAIT: begin
        // Wait until no EPC write is in flight, including one retiring right now.
        if (cp0bubble == 2'd0 && !epc_wr) begin
          eret_clr = 1'b1;
          flush_d  = 1'b1;
          redir_d  = 1'b1;
          target_d = epc_next;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall = ((state_q == ST_IDLE) && eret_req && (cp0bubble != 2'd0))
               || (state_q == ST_FLUSH) || (state_q == ST_ERET_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      redir_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      redir_q  <= redir_d;
      target_q <= target_d;
    end
  end

  assign flush       = flush_q;
  assign pc_redirect = redir_q;
  assign pc_target   = target_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed scenarios plus a randomized run against a cycle-scheduled reference model.
module tb_cp0_exc_ctrl;

  localparam int          FC  = 3;
  localparam logic [31:0] VEC = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  int_req;
  logic        exc_valid, eret_req, mtc0_we;
  logic [4:0]  exc_code, mtc0_addr;
  logic [31:0] mem_pc, mtc0_wdata;
  logic [1:0]  cp0bubble;
  logic [2:0]  mtc0_sel;
  logic        flush, stall, pc_redirect;
  logic [31:0] pc_target, status, cause, epc;

  int n_checks = 0;
  int n_errors = 0;

  cp0_exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .exc_valid(exc_valid),
    .exc_code(exc_code), .mem_pc(mem_pc), .eret_req(eret_req), .cp0bubble(cp0bubble),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_sel(mtc0_sel), .mtc0_wdata(mtc0_wdata),
    .flush(flush), .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .status(status), .cause(cause), .epc(epc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    int_req = '0; exc_valid = 1'b0; exc_code = '0; mem_pc = '0;
    eret_req = 1'b0; cp0bubble = '0;
    mtc0_we = 1'b0; mtc0_addr = '0; mtc0_sel = '0; mtc0_wdata = '0;
  endtask

  task automatic set_mtc0(input logic [4:0] addr, input logic [31:0] data);
    mtc0_we = 1'b1; mtc0_addr = addr; mtc0_sel = 3'd0; mtc0_wdata = data;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
    n_checks++; if (pc_redirect !== 1'b0) begin n_errors++; $display("FAIL reset_redirect got=%b exp=0", pc_redirect); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_checks++; if ({pc_target, status, cause, epc} !== 128'h0) begin n_errors++;
      $display("FAIL reset_regs got=%h %h %h %h exp=all 0", pc_target, status, cause, epc); end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exception();
    exc_valid = 1'b1; exc_code = 5'd12; mem_pc = 32'h100;
    tick();
    clear_inputs();
    n_checks++; if (epc !== 32'h100) begin n_errors++; $display("FAIL exc_epc got=%h exp=00000100", epc); end
    n_checks++; if (cause[6:2] !== 5'd12) begin n_errors++; $display("FAIL exc_code got=%0d exp=12", cause[6:2]); end
    n_checks++; if (status[1] !== 1'b1) begin n_errors++; $display("FAIL exc_exl got=%b exp=1", status[1]); end
    for (int i = 1; i <= 5; i++) begin
      n_checks++; if (flush !== (i <= FC + 1)) begin n_errors++;
        $display("FAIL exc_flush cycle=%0d got=%b exp=%b", i, flush, (i <= FC + 1)); end
      n_checks++; if (pc_redirect !== (i == FC + 1)) begin n_errors++;
        $display("FAIL exc_redirect cycle=%0d got=%b exp=%b", i, pc_redirect, (i == FC + 1)); end
      n_checks++; if (stall !== (i <= FC)) begin n_errors++;
        $display("FAIL exc_stall cycle=%0d got=%b exp=%b", i, stall, (i <= FC)); end
      if (i == FC + 1) begin
        n_checks++; if (pc_target !== VEC) begin n_errors++; $display("FAIL exc_target got=%h exp=%h", pc_target, VEC); end
      end
      tick();
    end
  endtask

  task automatic test_interrupt();
    set_mtc0(5'd12, 32'h0000_0401);
    int_req = 6'h01;
    tick();
    clear_inputs();
    int_req = 6'h01; mem_pc = 32'h300;
    n_checks++; if (status !== 32'h0000_0401) begin n_errors++; $display("FAIL int_status got=%h exp=00000401", status); end
    n_checks++; if (cause[10] !== 1'b1) begin n_errors++; $display("FAIL int_ip got=%b exp=1", cause[10]); end
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL int_early_flush got=%b exp=0", flush); end
    tick();
    n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL int_flush got=%b exp=1", flush); end
    n_checks++; if (cause[6:2] !== 5'd0) begin n_errors++; $display("FAIL int_code got=%0d exp=0", cause[6:2]); end
    n_checks++; if (epc !== 32'h300) begin n_errors++; $display("FAIL int_epc got=%h exp=00000300", epc); end
    n_checks++; if (status !== 32'h0000_0403) begin n_errors++; $display("FAIL int_status_exl got=%h exp=00000403", status); end
    for (int i = 2; i <= 7; i++) begin
      int_req = (i == 2) ? 6'h03 : 6'h01;
      tick();
      n_checks++; if (flush !== (i <= FC + 1)) begin n_errors++;
        $display("FAIL int_flush_seq cycle=%0d got=%b exp=%b", i, flush, (i <= FC + 1)); end
      n_checks++; if (pc_redirect !== (i == FC + 1)) begin n_errors++;
        $display("FAIL int_redirect cycle=%0d got=%b exp=%b", i, pc_redirect, (i == FC + 1)); end
    end
    clear_inputs();
    set_mtc0(5'd12, 32'h0);
    tick();
    clear_inputs();
  endtask

  task automatic test_eret_hazard();
    set_mtc0(5'd12, 32'h0000_0002);
    tick();
    set_mtc0(5'd14, 32'h200);
    tick();
    clear_inputs();
    eret_req = 1'b1; cp0bubble = 2'd2;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL eret_stall0 got=%b exp=1", stall); end
    tick();
    cp0bubble = 2'd1;
    #1;
    n_checks++; if (stall !== 1'b1 || pc_redirect !== 1'b0) begin n_errors++;
      $display("FAIL eret_wait1 stall=%b redirect=%b exp=1 0", stall, pc_redirect); end
    tick();
    cp0bubble = 2'd0;
    #1;
    n_checks++; if (stall !== 1'b1 || pc_redirect !== 1'b0) begin n_errors++;
      $display("FAIL eret_wait2 stall=%b redirect=%b exp=1 0", stall, pc_redirect); end
    tick();
    eret_req = 1'b0;
    #1;
    n_checks++; if (pc_redirect !== 1'b1 || flush !== 1'b1) begin n_errors++;
      $display("FAIL eret_redirect redirect=%b flush=%b exp=1 1", pc_redirect, flush); end
    n_checks++; if (pc_target !== 32'h200) begin n_errors++; $display("FAIL eret_target got=%h exp=00000200", pc_target); end
    n_checks++; if (status[1] !== 1'b0) begin n_errors++; $display("FAIL eret_exl got=%b exp=0", status[1]); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL eret_stall_end got=%b exp=0", stall); end
    tick();
    n_checks++; if (pc_redirect !== 1'b0) begin n_errors++; $display("FAIL eret_one_shot got=%b exp=0", pc_redirect); end
  endtask

  task automatic test_exc_vs_eret();
    exc_valid = 1'b1; exc_code = 5'd8; mem_pc = 32'h400; eret_req = 1'b1; cp0bubble = 2'd0;
    tick();
    clear_inputs();
    n_checks++; if (flush !== 1'b1 || pc_redirect !== 1'b0) begin n_errors++;
      $display("FAIL excvseret_first flush=%b redirect=%b exp=1 0", flush, pc_redirect); end
    n_checks++; if (cause[6:2] !== 5'd8 || epc !== 32'h400 || status[1] !== 1'b1) begin n_errors++;
      $display("FAIL excvseret_regs code=%0d epc=%h exl=%b exp=8 00000400 1", cause[6:2], epc, status[1]); end
    for (int i = 2; i <= 5; i++) begin
      tick();
      n_checks++; if (pc_redirect !== (i == FC + 1)) begin n_errors++;
        $display("FAIL excvseret_redirect cycle=%0d got=%b exp=%b", i, pc_redirect, (i == FC + 1)); end
      if (i == FC + 1) begin
        n_checks++; if (pc_target !== VEC) begin n_errors++; $display("FAIL excvseret_target got=%h exp=%h", pc_target, VEC); end
      end
    end
  endtask

  task automatic test_mtc0_entry();
    set_mtc0(5'd12, 32'h0000_0001);
    exc_valid = 1'b1; exc_code = 5'd10; mem_pc = 32'h500;
    tick();
    clear_inputs();
    n_checks++; if (status !== 32'h0000_0003) begin n_errors++; $display("FAIL mtc0_entry_status got=%h exp=00000003", status); end
    n_checks++; if (cause[6:2] !== 5'd10 || epc !== 32'h500) begin n_errors++;
      $display("FAIL mtc0_entry_regs code=%0d epc=%h exp=10 00000500", cause[6:2], epc); end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid_flush();
    exc_valid = 1'b1; exc_code = 5'd9; mem_pc = 32'h600;
    tick();
    clear_inputs();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if ({flush, pc_redirect, stall} !== 3'b000) begin n_errors++;
      $display("FAIL midreset_ctrl flush=%b redirect=%b stall=%b exp=0 0 0", flush, pc_redirect, stall); end
    n_checks++; if ({pc_target, status, cause, epc} !== 128'h0) begin n_errors++;
      $display("FAIL midreset_regs got=%h %h %h %h exp=all 0", pc_target, status, cause, epc); end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (pc_redirect !== 1'b0 || flush !== 1'b0) begin n_errors++;
        $display("FAIL midreset_after cycle=%0d redirect=%b flush=%b exp=0 0", i, pc_redirect, flush); end
    end
  endtask

  // Model: architectural fields as plain variables; pipeline effects scheduled by cycle number.
  task automatic test_random();
    bit          sf[0:511], sr[0:511], ss[0:511];
    logic [31:0] st[0:511];
    bit          ie = 0, exl = 0, waiting = 0;
    logic [7:0]  im = '0;
    logic [1:0]  ipsw = '0;
    logic [5:0]  iphw = '0;
    logic [4:0]  code = '0;
    logic [31:0] mepc = '0;
    int          busy_until = -1;
    bit          idle, pend, wr_epc, do_eret, exp_stall;
    logic [31:0] exp_st, exp_ca;
    for (int i = 0; i < 512; i++) begin sf[i] = 0; sr[i] = 0; ss[i] = 0; st[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      exp_st = {16'h0, im, 6'h0, exl, ie};
      exp_ca = {16'h0, iphw, ipsw, 1'b0, code, 2'b00};
      n_checks++; if (flush !== sf[c]) begin n_errors++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, flush, sf[c]); end
      n_checks++; if (pc_redirect !== sr[c]) begin n_errors++; $display("FAIL rnd_redirect c=%0d got=%b exp=%b", c, pc_redirect, sr[c]); end
      if (sr[c]) begin
        n_checks++; if (pc_target !== st[c]) begin n_errors++; $display("FAIL rnd_target c=%0d got=%h exp=%h", c, pc_target, st[c]); end
      end
      n_checks++; if (status !== exp_st) begin n_errors++; $display("FAIL rnd_status c=%0d got=%h exp=%h", c, status, exp_st); end
      n_checks++; if (cause !== exp_ca) begin n_errors++; $display("FAIL rnd_cause c=%0d got=%h exp=%h", c, cause, exp_ca); end
      n_checks++; if (epc !== mepc) begin n_errors++; $display("FAIL rnd_epc c=%0d got=%h exp=%h", c, epc, mepc); end

      exc_valid  = ($urandom_range(9) == 0);
      exc_code   = 5'($urandom);
      mem_pc     = $urandom;
      eret_req   = ($urandom_range(5) == 0);
      cp0bubble  = ($urandom_range(2) == 0) ? 2'($urandom) : 2'd0;
      int_req    = ($urandom_range(3) == 0) ? 6'($urandom) : 6'd0;
      mtc0_we    = ($urandom_range(3) == 0);
      case ($urandom_range(3))
        0: mtc0_addr = 5'd12;
        1: mtc0_addr = 5'd13;
        2: mtc0_addr = 5'd14;
        default: mtc0_addr = 5'($urandom);
      endcase
      mtc0_sel   = ($urandom_range(7) == 0) ? 3'($urandom) : 3'd0;
      mtc0_wdata = $urandom;

      idle = (c > busy_until) && !waiting;
      exp_stall = ss[c] || waiting || (idle && eret_req && cp0bubble != 2'd0);
      #1;
      n_checks++; if (stall !== exp_stall) begin n_errors++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, exp_stall); end

      pend = ie && !exl && (({iphw, ipsw} & im) != 8'h0);
      wr_epc = mtc0_we && mtc0_sel == 3'd0 && mtc0_addr == 5'd14;
      if (mtc0_we && mtc0_sel == 3'd0) begin
        if (mtc0_addr == 5'd12) begin ie = mtc0_wdata[0]; exl = mtc0_wdata[1]; im = mtc0_wdata[15:8]; end
        if (mtc0_addr == 5'd13) ipsw = mtc0_wdata[9:8];
        if (mtc0_addr == 5'd14) mepc = mtc0_wdata;
      end
      iphw = int_req;
      do_eret = 0;
      if (idle) begin
        if (exc_valid || pend) begin
          mepc = mem_pc;
          code = exc_valid ? exc_code : 5'd0;
          exl  = 1;
          for (int k = 1; k <= FC + 1; k++) sf[c + k] = 1;
          for (int k = 1; k <= FC; k++) ss[c + k] = 1;
          sr[c + FC + 1] = 1;
          st[c + FC + 1] = VEC;
          busy_until = c + FC + 1;
        end else if (eret_req) begin
          if (cp0bubble == 2'd0) do_eret = 1;
          else waiting = 1;
        end
      end else if (waiting && cp0bubble == 2'd0 && !wr_epc) begin
        do_eret = 1;
        waiting = 0;
      end
      if (do_eret) begin
        exl = 0;
        sf[c + 1] = 1; sr[c + 1] = 1; st[c + 1] = mepc;
      end
      @(posedge clk);
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_exception();
    test_interrupt();
    test_eret_hazard();
    test_exc_vs_eret();
    test_mtc0_entry();
    test_reset_mid_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
